// File: rtl/cc_capture_ctrl.sv
// cc_capture_ctrl -- CMOS sensor capture controller.
//
// Gates the incoming pixel stream to a requested number of whole frames and
// measures per-frame statistics (cycles, valid beats, lines).
//
// Optional feature macro: CC_LINE_COUNT_EN
//   defined   : hsync rising edges are counted and reported on lines_per_frame_o
//   undefined : no hsync edge logic, lines_per_frame_o is tied to 0
//
// Ports
//   cmos_clk_i          capture clock, all registers update on its rising edge
//   rst                 synchronous active-high reset
//   cmos_data_i         pixel data (DATA_W)
//   cmos_vsync_i        frame sync, polarity selected by vsync_pol_i
//   cmos_hsync_i        line sync (active-high)
//   cmos_valid_i        pixel data valid
//   vsync_pol_i         0 = vsync active-high, 1 = active-low
//   arm_i               start request, accepted in IDLE only
//   abort_i             stop request; in CAPTURE the current frame completes
//   frame_cnt_i         frames to capture (0 = continuous), latched on arm
//   cmos_en_o           gated valid, one cycle after cmos_valid_i
//   cmos_data_o         cmos_data_i delayed one cycle
//   sof_o/eof_o         start/end of captured frame pulses
//   done_o              capture finished pulse (coincides with last eof_o)
//   stats_vld_o         statistics outputs updated pulse
//   busy_o              controller not IDLE
//   frame_length_o      cycles in last frame
//   valid_per_frame_o   valid beats in last frame
//   lines_per_frame_o   hsync rising edges in last frame
//   frames_done_o       frames completed in current or last capture

module cc_capture_ctrl #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned CNT_W  = 32,
    parameter int unsigned FRM_W  = 8
) (
    input  logic              cmos_clk_i,
    input  logic              rst,
    input  logic [DATA_W-1:0] cmos_data_i,
    input  logic              cmos_vsync_i,
    input  logic              cmos_hsync_i,
    input  logic              cmos_valid_i,
    input  logic              vsync_pol_i,
    input  logic              arm_i,
    input  logic              abort_i,
    input  logic [FRM_W-1:0]  frame_cnt_i,
    output logic              cmos_en_o,
    output logic [DATA_W-1:0] cmos_data_o,
    output logic              sof_o,
    output logic              eof_o,
    output logic              done_o,
    output logic              stats_vld_o,
    output logic              busy_o,
    output logic [CNT_W-1:0]  frame_length_o,
    output logic [CNT_W-1:0]  valid_per_frame_o,
    output logic [CNT_W-1:0]  lines_per_frame_o,
    output logic [FRM_W-1:0]  frames_done_o
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2
    } state_t;

    state_t state, state_next;

    logic vs, vs_q, vsync_edge;

    logic [FRM_W-1:0] target, target_next;
    logic [FRM_W-1:0] frames_next, frames_inc;
    logic             abort_lat, abort_next;
    logic             sof_next, eof_next, done_next;
    logic             end_capture;

    // Set by the first vsync edge after reset; that edge closes a partial
    // frame, so its statistics are discarded.
    logic             stats_primed;

    logic [CNT_W-1:0] len, len_inc;
    logic [CNT_W-1:0] vcnt, vcnt_inc;

    // ------------------------------------------------------------------
    // Frame sync edge detection
    // ------------------------------------------------------------------
    assign vs         = cmos_vsync_i ^ vsync_pol_i;
    assign vsync_edge = vs & ~vs_q;

    always_ff @(posedge cmos_clk_i) begin
        if (rst) begin
            vs_q <= 1'b0;
        end else begin
            vs_q <= vs;
        end
    end

    // ------------------------------------------------------------------
    // Control FSM: next state and pulse generation
    // ------------------------------------------------------------------
    assign frames_inc = (frames_done_o == '1) ? frames_done_o
                                              : frames_done_o + FRM_W'(1);

    always_comb begin
        state_next  = state;
        target_next = target;
        frames_next = frames_done_o;
        abort_next  = abort_lat;
        sof_next    = 1'b0;
        eof_next    = 1'b0;
        done_next   = 1'b0;
        end_capture = 1'b0;

        case (state)
            IDLE: begin
                // abort_i is meaningless here; arm wins
                if (arm_i) begin
                    state_next  = ARMED;
                    target_next = frame_cnt_i;
                    frames_next = '0;
                    abort_next  = 1'b0;
                end
            end

            ARMED: begin
                if (abort_i) begin
                    state_next = IDLE;
                end else if (vsync_edge) begin
                    state_next = CAPTURE;
                    sof_next   = 1'b1;
                end
            end

            CAPTURE: begin
                if (vsync_edge) begin
                    frames_next = frames_inc;
                    eof_next    = 1'b1;
                    abort_next  = 1'b0;
                    // abort seen anywhere in the closing frame, including
                    // this cycle, ends the capture at this frame boundary
                    if (((target != '0) && (frames_inc == target)) ||
                        abort_lat || abort_i) begin
                        end_capture = 1'b1;
                        done_next   = 1'b1;
                        state_next  = IDLE;
                    end else begin
                        sof_next = 1'b1;
                    end
                end else if (abort_i) begin
                    abort_next = 1'b1;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge cmos_clk_i) begin
        if (rst) begin
            state         <= IDLE;
            target        <= '0;
            frames_done_o <= '0;
            abort_lat     <= 1'b0;
            sof_o         <= 1'b0;
            eof_o         <= 1'b0;
            done_o        <= 1'b0;
        end else begin
            state         <= state_next;
            target        <= target_next;
            frames_done_o <= frames_next;
            abort_lat     <= abort_next;
            sof_o         <= sof_next;
            eof_o         <= eof_next;
            done_o        <= done_next;
        end
    end

    assign busy_o = (state != IDLE);

    // ------------------------------------------------------------------
    // Data path: one-cycle pipeline, valid gated to captured frames
    // ------------------------------------------------------------------
    always_ff @(posedge cmos_clk_i) begin
        if (rst) begin
            cmos_en_o   <= 1'b0;
            cmos_data_o <= '0;
        end else begin
            cmos_en_o   <= cmos_valid_i && (state == CAPTURE) && !end_capture;
            cmos_data_o <= cmos_data_i;
        end
    end

    // ------------------------------------------------------------------
    // Statistics (run regardless of FSM state, saturating)
    // ------------------------------------------------------------------
    assign len_inc  = (len == '1)  ? len  : len + CNT_W'(1);
    assign vcnt_inc = (vcnt == '1) ? vcnt : vcnt + CNT_W'(cmos_valid_i);

    always_ff @(posedge cmos_clk_i) begin
        if (rst) begin
            len               <= '0;
            vcnt              <= '0;
            stats_primed      <= 1'b0;
            frame_length_o    <= '0;
            valid_per_frame_o <= '0;
            stats_vld_o       <= 1'b0;
        end else begin
            stats_vld_o <= 1'b0;
            if (vsync_edge) begin
                // the edge cycle is the first cycle of the new frame
                len          <= CNT_W'(1);
                vcnt         <= CNT_W'(cmos_valid_i);
                stats_primed <= 1'b1;
                if (stats_primed) begin
                    frame_length_o    <= len;
                    valid_per_frame_o <= vcnt;
                    stats_vld_o       <= 1'b1;
                end
            end else begin
                len  <= len_inc;
                vcnt <= vcnt_inc;
            end
        end
    end

`ifdef CC_LINE_COUNT_EN
    logic             hs_q, hsync_edge;
    logic [CNT_W-1:0] lcnt, lcnt_inc, lines;

    assign hsync_edge = cmos_hsync_i & ~hs_q;
    assign lcnt_inc   = (lcnt == '1) ? lcnt : lcnt + CNT_W'(hsync_edge);

    always_ff @(posedge cmos_clk_i) begin
        if (rst) begin
            hs_q  <= 1'b0;
            lcnt  <= '0;
            lines <= '0;
        end else begin
            hs_q <= cmos_hsync_i;
            if (vsync_edge) begin
                lcnt <= '0;
                if (stats_primed) begin
                    lines <= lcnt;
                end
            end else begin
                lcnt <= lcnt_inc;
            end
        end
    end

    assign lines_per_frame_o = lines;
`else
    logic unused_hsync;
    assign unused_hsync      = cmos_hsync_i;
    assign lines_per_frame_o = '0;
`endif

endmodule

// File: tb/tb_cc_capture_ctrl.sv
module tb_cc_capture_ctrl;

    localparam int DW = 16;
    localparam int CW = 32;
    localparam int FW = 8;
    localparam int SCW = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic [DW-1:0] data;
    logic          vsync, hsync, valid, pol, arm, abort;
    logic [FW-1:0] fcnt;

    logic          en, sof, eof, done, svld, busy;
    logic [DW-1:0] dout;
    logic [CW-1:0] flen, vper, lper;
    logic [FW-1:0] fdone;

    logic           s_en, s_sof, s_eof, s_done, s_svld, s_busy;
    logic [DW-1:0]  s_dout;
    logic [SCW-1:0] s_flen, s_vper, s_lper;
    logic [FW-1:0]  s_fdone;

    cc_capture_ctrl #(.DATA_W(DW), .CNT_W(CW), .FRM_W(FW)) dut (
        .cmos_clk_i(clk), .rst(rst), .cmos_data_i(data),
        .cmos_vsync_i(vsync), .cmos_hsync_i(hsync), .cmos_valid_i(valid),
        .vsync_pol_i(pol), .arm_i(arm), .abort_i(abort), .frame_cnt_i(fcnt),
        .cmos_en_o(en), .cmos_data_o(dout), .sof_o(sof), .eof_o(eof),
        .done_o(done), .stats_vld_o(svld), .busy_o(busy),
        .frame_length_o(flen), .valid_per_frame_o(vper),
        .lines_per_frame_o(lper), .frames_done_o(fdone)
    );

    cc_capture_ctrl #(.DATA_W(DW), .CNT_W(SCW), .FRM_W(FW)) dut_small (
        .cmos_clk_i(clk), .rst(rst), .cmos_data_i(data),
        .cmos_vsync_i(vsync), .cmos_hsync_i(hsync), .cmos_valid_i(valid),
        .vsync_pol_i(pol), .arm_i(arm), .abort_i(abort), .frame_cnt_i(fcnt),
        .cmos_en_o(s_en), .cmos_data_o(s_dout), .sof_o(s_sof), .eof_o(s_eof),
        .done_o(s_done), .stats_vld_o(s_svld), .busy_o(s_busy),
        .frame_length_o(s_flen), .valid_per_frame_o(s_vper),
        .lines_per_frame_o(s_lper), .frames_done_o(s_fdone)
    );

    int checks = 0;
    int errors = 0;

    int n_sof, n_eof, n_done, n_en, n_svld, n_done_eof;

    always @(negedge clk) begin
        if (sof)  n_sof++;
        if (eof)  n_eof++;
        if (done) n_done++;
        if (en)   n_en++;
        if (svld) n_svld++;
        if (done && eof) n_done_eof++;
    end

`ifdef CC_LINE_COUNT_EN
    localparam int EXP_LINES = 10;
`else
    localparam int EXP_LINES = 0;
`endif

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_counts();
        n_sof = 0; n_eof = 0; n_done = 0; n_en = 0; n_svld = 0; n_done_eof = 0;
    endtask

    task automatic idle_inputs();
        data = '0; vsync = pol; hsync = 1'b0; valid = 1'b0;
        arm = 1'b0; abort = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        clr_counts();
    endtask

    task automatic do_arm(input logic [FW-1:0] n);
        arm = 1'b1;
        fcnt = n;
        step();
        arm = 1'b0;
    endtask

    // One frame: vsync active on cycle 0, valid on cycles 10..10+nv-1,
    // nh two-cycle hsync pulses every 8 cycles from cycle 5, abort on abort_at.
    task automatic run_frame(input int len, input int nv, input int nh, input int abort_at);
        for (int c = 0; c < len; c++) begin
            vsync = (c == 0) ? ~pol : pol;
            valid = (c >= 10) && (c < 10 + nv);
            hsync = (nh > 0) && (c >= 5) && (((c - 5) % 8) < 2) && (((c - 5) / 8) < nh);
            abort = (c == abort_at);
            data  = DW'($urandom);
            step();
        end
        idle_inputs();
    endtask

    task automatic test_reset();
        pol = 1'b0;
        fcnt = '0;
        do_reset();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %0d want 0", busy); end
        checks++; if (en !== 1'b0) begin errors++; $display("FAIL rst_en: got %0d want 0", en); end
        checks++; if (dout !== '0) begin errors++; $display("FAIL rst_data: got %0h want 0", dout); end
        checks++; if ({sof, eof, done, svld} !== 4'b0) begin errors++; $display("FAIL rst_pulses: got %b want 0000", {sof, eof, done, svld}); end
        checks++; if (flen !== '0) begin errors++; $display("FAIL rst_flen: got %0d want 0", flen); end
        checks++; if (vper !== '0) begin errors++; $display("FAIL rst_vper: got %0d want 0", vper); end
        checks++; if (lper !== '0) begin errors++; $display("FAIL rst_lper: got %0d want 0", lper); end
        checks++; if (fdone !== '0) begin errors++; $display("FAIL rst_fdone: got %0d want 0", fdone); end
    endtask

    task automatic test_data_path();
        valid = 1'b1;
        data  = 16'h3C5A;
        step();
        checks++; if (dout !== 16'h3C5A) begin errors++; $display("FAIL data_latency: got %0h want 3c5a", dout); end
        checks++; if (en !== 1'b0) begin errors++; $display("FAIL en_idle_gated: got %0d want 0", en); end
        idle_inputs();
        step();
    endtask

    task automatic test_frame_count();
        pol = 1'b0;
        do_reset();
        do_arm(8'd2);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL fc_armed_busy: got %0d want 1", busy); end
        for (int f = 0; f < 3; f++) run_frame(100, 40, 0, -1);
        checks++; if (n_sof != 2) begin errors++; $display("FAIL fc_sof: got %0d want 2", n_sof); end
        checks++; if (n_eof != 2) begin errors++; $display("FAIL fc_eof: got %0d want 2", n_eof); end
        checks++; if (n_done != 1) begin errors++; $display("FAIL fc_done: got %0d want 1", n_done); end
        checks++; if (n_done_eof != 1) begin errors++; $display("FAIL fc_done_with_eof: got %0d want 1", n_done_eof); end
        checks++; if (fdone !== 8'd2) begin errors++; $display("FAIL fc_frames_done: got %0d want 2", fdone); end
        checks++; if (n_en != 80) begin errors++; $display("FAIL fc_en_count: got %0d want 80", n_en); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL fc_idle_after: got %0d want 0", busy); end
        checks++; if (flen !== 32'd100) begin errors++; $display("FAIL fc_flen: got %0d want 100", flen); end
        checks++; if (vper !== 32'd40) begin errors++; $display("FAIL fc_vper: got %0d want 40", vper); end
        checks++; if (n_svld != 2) begin errors++; $display("FAIL fc_stats_vld: got %0d want 2", n_svld); end
    endtask

    task automatic test_polarity();
        pol = 1'b1;
        do_reset();
        for (int f = 0; f < 3; f++) run_frame(200, 50, 10, -1);
        checks++; if (flen !== 32'd200) begin errors++; $display("FAIL pol_flen: got %0d want 200", flen); end
        checks++; if (vper !== 32'd50) begin errors++; $display("FAIL pol_vper: got %0d want 50", vper); end
        checks++; if (lper !== 32'(EXP_LINES)) begin errors++; $display("FAIL pol_lper: got %0d want %0d", lper, EXP_LINES); end
        checks++; if (n_svld != 2) begin errors++; $display("FAIL pol_stats_vld: got %0d want 2", n_svld); end
        checks++; if (n_en != 0) begin errors++; $display("FAIL pol_en_unarmed: got %0d want 0", n_en); end
        pol = 1'b0;
        idle_inputs();
        step();
    endtask

    task automatic test_abort_continuous();
        pol = 1'b0;
        do_reset();
        do_arm(8'd0);
        run_frame(100, 40, 0, -1);
        run_frame(100, 40, 0, -1);
        run_frame(100, 40, 0, 30);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ab_busy_after_abort: got %0d want 1", busy); end
        checks++; if (n_done != 0) begin errors++; $display("FAIL ab_done_early: got %0d want 0", n_done); end
        run_frame(100, 40, 0, -1);
        checks++; if (n_en != 120) begin errors++; $display("FAIL ab_en_count: got %0d want 120", n_en); end
        checks++; if (n_done != 1) begin errors++; $display("FAIL ab_done: got %0d want 1", n_done); end
        checks++; if (n_done_eof != 1) begin errors++; $display("FAIL ab_done_with_eof: got %0d want 1", n_done_eof); end
        checks++; if (fdone !== 8'd3) begin errors++; $display("FAIL ab_frames_done: got %0d want 3", fdone); end
        checks++; if (n_sof != 3) begin errors++; $display("FAIL ab_sof: got %0d want 3", n_sof); end
        checks++; if (n_eof != 3) begin errors++; $display("FAIL ab_eof: got %0d want 3", n_eof); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ab_idle_after: got %0d want 0", busy); end
    endtask

    task automatic test_armed_abort_and_arm_ignore();
        pol = 1'b0;
        do_reset();
        do_arm(8'd1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL aa_idle: got %0d want 0", busy); end
        checks++; if ((n_sof + n_done) != 0) begin errors++; $display("FAIL aa_no_pulses: got %0d want 0", n_sof + n_done); end
        arm = 1'b1; abort = 1'b1; fcnt = 8'd1;
        step();
        arm = 1'b0; abort = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL aa_arm_wins: got %0d want 1", busy); end
        run_frame(100, 40, 0, -1);
        checks++; if (n_sof != 1) begin errors++; $display("FAIL aa_sof: got %0d want 1", n_sof); end
        do_arm(8'd5);
        step();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL aa_arm_ignored_busy: got %0d want 1", busy); end
        run_frame(100, 40, 0, -1);
        checks++; if (n_done != 1) begin errors++; $display("FAIL aa_done_target1: got %0d want 1", n_done); end
        checks++; if (fdone !== 8'd1) begin errors++; $display("FAIL aa_frames_done: got %0d want 1", fdone); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL aa_idle_end: got %0d want 0", busy); end
    endtask

    task automatic test_reset_mid_capture();
        pol = 1'b0;
        do_reset();
        do_arm(8'd0);
        run_frame(100, 40, 0, -1);
        run_frame(100, 40, 0, -1);
        run_frame(30, 20, 0, -1);
        clr_counts();
        rst = 1'b1; valid = 1'b1; data = 16'hFFFF;
        step();
        rst = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rm_busy: got %0d want 0", busy); end
        checks++; if ({en, sof, eof, done, svld} !== 5'b0) begin errors++; $display("FAIL rm_pulses: got %b want 00000", {en, sof, eof, done, svld}); end
        checks++; if (dout !== '0) begin errors++; $display("FAIL rm_data: got %0h want 0", dout); end
        checks++; if (flen !== '0 || vper !== '0) begin errors++; $display("FAIL rm_stats: got %0d/%0d want 0/0", flen, vper); end
        checks++; if (fdone !== '0) begin errors++; $display("FAIL rm_fdone: got %0d want 0", fdone); end
        idle_inputs();
        run_frame(100, 40, 0, -1);
        checks++; if ((n_eof + n_done) != 0) begin errors++; $display("FAIL rm_no_eof_done: got %0d want 0", n_eof + n_done); end
        checks++; if (n_svld != 0) begin errors++; $display("FAIL rm_first_edge_stats: got %0d want 0", n_svld); end
        run_frame(10, 0, 0, -1);
        checks++; if (n_svld != 1) begin errors++; $display("FAIL rm_second_edge_stats: got %0d want 1", n_svld); end
        checks++; if (flen !== 32'd100) begin errors++; $display("FAIL rm_flen: got %0d want 100", flen); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rm_still_idle: got %0d want 0", busy); end
    endtask

    task automatic test_saturation();
        pol = 1'b0;
        do_reset();
        run_frame(20, 5, 0, -1);
        run_frame(20, 5, 0, -1);
        run_frame(1, 0, 0, -1);
        checks++; if (s_flen !== 4'd15) begin errors++; $display("FAIL sat_flen: got %0d want 15", s_flen); end
        checks++; if (s_vper !== 4'd5) begin errors++; $display("FAIL sat_vper: got %0d want 5", s_vper); end
        checks++; if (flen !== 32'd20) begin errors++; $display("FAIL sat_wide_flen: got %0d want 20", flen); end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        pol = 1'b0;
        fcnt = '0;
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_data_path();
        test_frame_count();
        test_polarity();
        test_abort_continuous();
        test_armed_abort_and_arm_ignore();
        test_reset_mid_capture();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cc_capture_ctrl.md
CC_CAPTURE_CTRL -- requirements
Module: cc_capture_ctrl

Interface
REQ-001 Parameter: DATA_W, 16, CMOS pixel data width.
REQ-002 Parameter: CNT_W, 32, width of every statistics counter.
REQ-003 Parameter: FRM_W, 8, width of frame-count request and captured-frame counter.
REQ-004 Port: cmos_clk_i  in  1  capture clock; every register changes on its rising edge.
REQ-005 Port: rst  in  1  reset, synchronous, active-high.
REQ-006 Port: cmos_data_i  in  DATA_W  pixel data.
REQ-007 Port: cmos_vsync_i / cmos_hsync_i / cmos_valid_i  in  1 each  frame sync, line sync, data valid.
REQ-008 Port: vsync_pol_i  in  1  0 = vsync active-high, 1 = active-low.
REQ-009 Port: arm_i  in  1  start request, sampled in IDLE only.
REQ-010 Port: abort_i  in  1  stop request.
REQ-011 Port: frame_cnt_i  in  FRM_W  frames to capture, sampled when arm_i is accepted; 0 = continuous.
REQ-012 Port: cmos_en_o / cmos_data_o  out  1 / DATA_W  gated valid and its data.
REQ-013 Port: sof_o / eof_o / done_o / stats_vld_o  out  1 each  single-cycle pulses.
REQ-014 Port: busy_o  out  1  high when state is not IDLE.
REQ-015 Port: frame_length_o / valid_per_frame_o / lines_per_frame_o  out  CNT_W each  last-frame statistics.
REQ-016 Port: frames_done_o  out  FRM_W  frames completed in current or last capture.

Function
REQ-017 vs = cmos_vsync_i XOR vsync_pol_i; vs_q = vs registered; vsync_edge = vs AND NOT vs_q (combinational).
REQ-018 States IDLE, ARMED, CAPTURE; IDLE->ARMED on arm_i (latch frame_cnt_i, clear frames_done_o); ARMED->CAPTURE on vsync_edge; ARMED->IDLE on abort_i with no done_o.
REQ-019 In CAPTURE, each vsync_edge increments frames_done_o and pulses eof_o next cycle; capture ends when new frames_done_o equals latched count (nonzero), or abort_i was seen since last vsync_edge.
REQ-020 Capture end: state -> IDLE, done_o pulses together with eof_o; otherwise remain CAPTURE and pulse sof_o together with eof_o.
REQ-021 ARMED->CAPTURE edge pulses sof_o next cycle; abort_i in CAPTURE is latched until the next vsync_edge (frame completes whole).
REQ-022 cmos_en_o = cmos_valid_i registered, masked by (state == CAPTURE and no vsync_edge ending capture) in the sampled cycle; cmos_data_o = cmos_data_i registered unconditionally; latency exactly 1 cycle.
REQ-023 Statistics run in every state: len counts every cycle, vcnt counts cmos_valid_i cycles, lcnt counts hsync rising edges.
REQ-024 On vsync_edge: outputs load len, vcnt, lcnt; len reloads 1, vcnt reloads cmos_valid_i, lcnt reloads 0; stats_vld_o pulses next cycle.
REQ-025 Counters saturate at all-ones, never wrap.
REQ-026 arm_i while busy_o high is ignored; arm_i and abort_i together in IDLE -> ARMED (abort ignored in IDLE).
REQ-027 frames_done_o saturates at all-ones in continuous mode.

Reset
REQ-028 rst has priority over all events: state IDLE, vs_q 0, all counters and outputs 0, latched abort cleared.
REQ-029 Reset mid-capture abandons frame with no eof_o or done_o; first vsync_edge after reset only starts statistics.

Configuration
REQ-030 Macro CC_LINE_COUNT_EN defined: lcnt and lines_per_frame_o implemented per REQ-023/024.
REQ-031 Macro undefined: no hsync edge logic; lines_per_frame_o constant 0; all other behaviour identical.

Verification
REQ-032 frame_cnt_i=2, arm, 3 vsync frames of 100 cycles with 40 valid -> sof_o twice, eof_o twice, done_o with 2nd eof_o, frames_done_o=2, cmos_en_o count 80, third frame gated.
REQ-033 vsync_pol_i=1, vsync low-pulse every 200 cycles, 50 valid, 10 hsync pulses -> frame_length_o=200, valid_per_frame_o=50, lines_per_frame_o=10 (0 without CC_LINE_COUNT_EN).
REQ-034 frame_cnt_i=0, abort_i mid 3rd frame -> capture continues to 3rd vsync_edge, done_o then, frames_done_o=3, no en after.
REQ-035 abort_i in ARMED -> IDLE next cycle, no sof_o/done_o; arm_i during CAPTURE -> ignored.
REQ-036 rst asserted mid-frame in CAPTURE -> next cycle all outputs 0, state IDLE, no done_o; CNT_W=4 with 20-cycle frame -> frame_length_o=15.
